sr_flip_flop: RTL and testbench

- Single-bit clocked SR flip-flop with complementary outputs.
- Samples a 2-bit set/reset command on the rising clock edge.
- Used as a basic storage or control element in digital lab datapaths.
- Includes a configurable policy for the illegal S=R=1 command and a registered flag that reports it.

---
 rtl/sr_flip_flop.sv | 72 +++++++
 tb/tb_sr_flip_flop.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sr_flip_flop.sv
// Clocked SR flip-flop with complementary outputs, a selectable policy for the
// S=R=1 command and a registered flag that marks each illegal sample.
module sr_flip_flop #(
    parameter logic RESET_VALUE  = 1'b0,
    parameter int   INVALID_MODE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sr,
    output logic       q,
    output logic       qb,
    output logic       invalid
);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'd0,
        MODE_TOGGLE = 2'd1,
        MODE_CLEAR  = 2'd2,
        MODE_SET    = 2'd3
    } illegal_mode_e;

    // Out-of-range policy values collapse to hold.
    localparam illegal_mode_e MODE = (INVALID_MODE >= 0 && INVALID_MODE <= 3)
                                     ? illegal_mode_e'(INVALID_MODE[1:0])
                                     : MODE_HOLD;

    logic state_q;
    logic state_d;
    logic invalid_q;
    logic invalid_d;
    logic illegal_state;

    always_comb begin
        illegal_state = state_q;
        case (MODE)
            MODE_TOGGLE: illegal_state = ~state_q;
            MODE_CLEAR:  illegal_state = 1'b0;
            MODE_SET:    illegal_state = 1'b1;
            default:     illegal_state = state_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        invalid_d = 1'b0;
        case (sr)
            2'b01: state_d = 1'b0;
            2'b10: state_d = 1'b1;
            2'b11: begin
                state_d   = illegal_state;
                invalid_d = 1'b1;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RESET_VALUE;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            invalid_q <= invalid_d;
        end
    end

    // qb comes from the same register, so q and qb can never agree.
    assign q       = state_q;
    assign qb      = ~state_q;
    assign invalid = invalid_q;

endmodule

// File: tb/tb_sr_flip_flop.sv
// Scoreboard bench: five flip-flop instances (all illegal-command policies and
// both reset values) driven in lockstep and checked against a behavioural model.
module tb_sr_flip_flop;

    localparam int N = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sr  = 2'b00;
    logic [N-1:0] q_o;
    logic [N-1:0] qb_o;
    logic [N-1:0] inv_o;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        sr_flip_flop #(
            .RESET_VALUE (gi == 4 ? 1'b1 : 1'b0),
            .INVALID_MODE(gi == 4 ? 1 : gi)
        ) u_dut (
            .clk    (clk),
            .rst    (rst),
            .sr     (sr),
            .q      (q_o[gi]),
            .qb     (qb_o[gi]),
            .invalid(inv_o[gi])
        );
    end

    typedef struct packed {
        logic [N-1:0] q;
        logic [N-1:0] inv;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    logic model_q [N];
    int   model_mode [N] = '{0, 1, 2, 3, 1};
    logic model_rv [N]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Spec rules: 01 clears, 10 sets, 11 follows the instance's policy.
    function automatic logic next_state(int mode, logic cur, logic [1:0] cmd);
        if (cmd == 2'b01) return 1'b0;
        if (cmd == 2'b10) return 1'b1;
        if (cmd == 2'b00) return cur;
        if (mode == 1) return !cur;
        if (mode == 2) return 1'b0;
        if (mode == 3) return 1'b1;
        return cur;
    endfunction

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s txn=%0d actual=%b required=%b", name, txn, act, req);
        end
    endtask

    task automatic step(input logic rv, input logic [1:0] cmd, input bit glitch);
        exp_t e;
        @(negedge clk);
        if (glitch) begin
            sr = ~cmd;
            #1 sr = cmd;
            #1 sr = ~cmd;
            #1;
        end
        sr  = cmd;
        rst = rv;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            model_q[i] = rv ? model_rv[i] : next_state(model_mode[i], model_q[i], cmd);
            e.q[i]     = model_q[i];
            e.inv[i]   = !rv && (cmd == 2'b11);
        end
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle; check just after the edge and
    // again just before the next one to catch any path from sr to outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                check("q", q_o, e.q);
                check("qb", qb_o, ~e.q);
                check("invalid", inv_o, e.inv);
                $display("txn %0d rst=%b sr=%b q=%b qb=%b invalid=%b", txn, rst, sr, q_o, qb_o, inv_o);
                #7;
                check("q_hold", q_o, e.q);
                check("invalid_hold", inv_o, e.inv);
            end
        end
    end

    initial begin
        // Reset with S asserted for two edges.
        step(1'b1, 2'b10, 0);
        step(1'b1, 2'b10, 0);
        // Basic sequence.
        step(1'b0, 2'b00, 0); step(1'b0, 2'b00, 0);
        step(1'b0, 2'b01, 0); step(1'b0, 2'b01, 0);
        step(1'b0, 2'b10, 0); step(1'b0, 2'b10, 0);
        step(1'b0, 2'b00, 0); step(1'b0, 2'b00, 0);
        step(1'b0, 2'b01, 0); step(1'b0, 2'b01, 0);
        // Mid-cycle glitch settling to S.
        step(1'b0, 2'b10, 1);
        // Illegal command from q=1, then a hold.
        step(1'b0, 2'b10, 0);
        step(1'b0, 2'b11, 0);
        step(1'b0, 2'b00, 0);
        // Held illegal command from q=0.
        step(1'b0, 2'b01, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 2'b11, 0);
        step(1'b0, 2'b00, 0);
        // Reset priority over a simultaneous set.
        step(1'b0, 2'b10, 0);
        step(1'b1, 2'b10, 0);
        step(1'b0, 2'b10, 0);
        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
        end
        step(1'b0, 2'b00, 0);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
